// File: rtl/motion_detect_pkg.sv
// Shared types for the motion-detect pixel pipeline.
// Pixel/pair widths and the pair sequencer state encoding.
package motion_detect_pkg;

  localparam int PIXEL_W = 8;
  localparam int PAIR_W  = 2 * PIXEL_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERROR
  } seq_state_t;

endpackage

// File: rtl/pixel_pos_counter.sv
// Column/row position tracker for one WIDTH x HEIGHT frame.
// Advances on inc, wraps to origin after the last pixel.
module pixel_pos_counter #(
  parameter  int WIDTH  = 768,
  parameter  int HEIGHT = 576,
  localparam int CW     = $clog2(WIDTH),
  localparam int RW     = $clog2(HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          first,
  output logic          last
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_last_col;
  logic          w_last_row;

  assign w_last_col = (r_col == CW'(WIDTH - 1));
  assign w_last_row = (r_row == RW'(HEIGHT - 1));

  assign col   = r_col;
  assign row   = r_row;
  assign first = (r_col == '0) && (r_row == '0);
  assign last  = w_last_col && w_last_row;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_pair_sequencer.sv
// Pops base/ped pixels in lockstep and emits 16-bit pairs
// with frame flags, a skew watchdog and a start/done FSM.
module frame_pair_sequencer
  import motion_detect_pkg::*;
#(
  parameter int WIDTH        = 768,
  parameter int HEIGHT       = 576,
  parameter int SKEW_TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              base_empty,
  input  logic [PIXEL_W-1:0] base_dout,
  output logic              base_rd_en,
  input  logic              ped_empty,
  input  logic [PIXEL_W-1:0] ped_dout,
  output logic              ped_rd_en,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [PAIR_W-1:0] out_din,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       frame_count
);

  localparam int CW  = $clog2(WIDTH);
  localparam int RW  = $clog2(HEIGHT);
  localparam int SKW = $clog2(SKEW_TIMEOUT) + 1;

  seq_state_t     r_state;
  seq_state_t     w_next;
  logic [SKW-1:0] r_skew_cnt;
  logic [15:0]    r_frame_count;

  logic          w_run;
  logic          w_fire;
  logic          w_skewed;
  logic          w_timeout;
  logic          w_pos_clr;
  logic          w_first;
  logic          w_last;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;

  pixel_pos_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_pos (
    .clock(clock),
    .reset(reset),
    .inc  (w_fire),
    .clr  (w_pos_clr),
    .col  (w_col),
    .row  (w_row),
    .first(w_first),
    .last (w_last)
  );

  assign w_run  = (r_state == RUN);
  assign w_fire = w_run & ~base_empty & ~ped_empty & ~out_full;

  // Back-pressure never counts: a full sink stalls both streams equally.
  assign w_skewed  = w_run & (base_empty ^ ped_empty) & ~out_full;
  assign w_timeout = w_skewed &
                     (r_skew_cnt == SKW'(SKEW_TIMEOUT - 1));

  assign base_rd_en  = w_fire;
  assign ped_rd_en   = w_fire;
  assign out_wr_en   = w_fire;
  assign out_din     = w_fire ? {base_dout, ped_dout} : '0;
  assign out_sof     = w_fire & w_first;
  assign out_eof     = w_fire & w_last;
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign error       = (r_state == ERROR);
  assign frame_count = r_frame_count;

  always_comb begin
    w_next    = r_state;
    w_pos_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next    = RUN;
          w_pos_clr = 1'b1;
        end
      end
      RUN: begin
        if (w_timeout) begin
          w_next = ERROR;
        end else if (w_fire && w_last) begin
          w_next = DONE;
        end
      end
      DONE: w_next = IDLE;
      ERROR: begin
        if (clear) begin
          w_next    = IDLE;
          w_pos_clr = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_skew_cnt    <= '0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_skewed) begin
        r_skew_cnt <= r_skew_cnt + 1'b1;
      end else begin
        r_skew_cnt <= '0;
      end
      if (w_fire && w_last) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_pair_sequencer.sv
// Self-checking bench: queue-modelled FWFT FIFOs and a
// frame-level reference for pairs, flags and the watchdog.
module tb_frame_pair_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset, start, clear;
  logic        base_empty, ped_empty, out_full;
  logic [7:0]  base_dout, ped_dout;
  logic        base_rd_en, ped_rd_en, out_wr_en;
  logic [15:0] out_din;
  logic        out_sof, out_eof, busy, done, error;
  logic [15:0] frame_count;

  always #5 clock = ~clock;

  frame_pair_sequencer #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .SKEW_TIMEOUT(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .clear      (clear),
    .base_empty (base_empty),
    .base_dout  (base_dout),
    .base_rd_en (base_rd_en),
    .ped_empty  (ped_empty),
    .ped_dout   (ped_dout),
    .ped_rd_en  (ped_rd_en),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .frame_count(frame_count)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  base_q[$];
  logic [7:0]  ped_q[$];
  bit          hold_b, hold_p;
  logic        s_wr, s_brd, s_prd, s_sof, s_eof;
  logic        s_busy, s_done, s_err;
  logic [15:0] s_din, s_fc;
  logic [15:0] m_fc;

  // One clock: present FIFO heads, sample before the edge, pop after.
  task automatic tick();
    base_empty = (base_q.size() == 0) || hold_b;
    ped_empty  = (ped_q.size() == 0) || hold_p;
    base_dout  = (base_q.size() != 0) ? base_q[0] : 8'h00;
    ped_dout   = (ped_q.size() != 0) ? ped_q[0] : 8'h00;
    #1;
    s_wr   = out_wr_en;
    s_brd  = base_rd_en;
    s_prd  = ped_rd_en;
    s_din  = out_din;
    s_sof  = out_sof;
    s_eof  = out_eof;
    s_busy = busy;
    s_done = done;
    s_err  = error;
    s_fc   = frame_count;
    @(posedge clock);
    #1;
    if (s_brd && base_q.size() != 0) void'(base_q.pop_front());
    if (s_prd && ped_q.size() != 0) void'(ped_q.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    clear = 1'b0;
    out_full = 1'b0;
    hold_b = 0;
    hold_p = 0;
    base_q.push_back(8'hAA);
    ped_q.push_back(8'h55);
    tick();
    n_vec++;
    if ({s_wr, s_brd, s_prd, s_sof, s_eof, s_busy, s_done, s_err} !== 8'h00 ||
        s_fc !== 16'h0000 || s_din !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b fc=%h din=%h, want 0",
               {s_wr, s_brd, s_prd, s_sof, s_eof, s_busy, s_done, s_err},
               s_fc, s_din);
    end
    reset = 1'b0;
    start = 1'b0;
    base_q.delete();
    ped_q.delete();
    tick();
    n_vec++;
    if (s_busy !== 1'b0 || s_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b wr=%b, want 0 0", s_busy, s_wr);
    end
    m_fc = 16'h0000;
  endtask

  // mode 0: free flow, 1: out_full toggles, 2: random stalls/data.
  task automatic test_frame(input int mode, input bit poke_done);
    int          idx;
    int          cyc;
    bit          ef;
    logic [15:0] ed;
    idx = 0;
    cyc = 0;
    base_q.delete();
    ped_q.delete();
    hold_b = 0;
    hold_p = 0;
    out_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      base_q.push_back(mode == 2 ? 8'($urandom) : 8'(8'h10 + i));
      ped_q.push_back(mode == 2 ? 8'($urandom) : 8'(8'h20 + i));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (s_wr !== 1'b0 || s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_start m%0d: wr=%b busy=%b, want 0 0",
               mode, s_wr, s_busy);
    end
    while (idx < N && cyc < 200) begin
      case (mode)
        1: out_full = cyc[0];
        2: begin
          out_full = 1'($urandom_range(0, 1));
          hold_b   = ($urandom_range(0, 4) == 0);
          hold_p   = ($urandom_range(0, 4) == 0);
        end
        default: out_full = 1'b0;
      endcase
      ef = base_q.size() != 0 && ped_q.size() != 0 &&
           !hold_b && !hold_p && !out_full;
      ed = ef ? {base_q[0], ped_q[0]} : 16'h0000;
      tick();
      n_vec++;
      if (s_wr !== ef || s_brd !== ef || s_prd !== ef ||
          s_sof !== (ef && idx == 0) || s_eof !== (ef && idx == N - 1) ||
          s_busy !== 1'b1 || s_err !== 1'b0) begin
        n_bad++;
        $display("FAIL handshake m%0d c%0d: wr/rd=%b%b%b sof=%b eof=%b busy=%b err=%b, want fire=%b idx=%0d",
                 mode, cyc, s_wr, s_brd, s_prd, s_sof, s_eof, s_busy,
                 s_err, ef, idx);
      end
      if (ef) begin
        n_vec++;
        if (s_din !== ed) begin
          n_bad++;
          $display("FAIL pair m%0d idx%0d: got %h, want %h",
                   mode, idx, s_din, ed);
        end
        idx++;
      end
      cyc++;
    end
    if (idx < N) begin
      n_bad++;
      $display("FAIL frame_timeout m%0d: got %0d pairs, want %0d",
               mode, idx, N);
    end
    hold_b = 0;
    hold_p = 0;
    out_full = 1'b0;
    m_fc = m_fc + 16'h1;
    start = poke_done;
    tick();
    start = 1'b0;
    n_vec++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_wr !== 1'b0 ||
        s_fc !== m_fc) begin
      n_bad++;
      $display("FAIL done_cycle m%0d: done=%b busy=%b wr=%b fc=%h, want 1 0 0 %h",
               mode, s_done, s_busy, s_wr, s_fc, m_fc);
    end
    tick();
    n_vec++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_wr !== 1'b0 ||
        s_fc !== m_fc || base_q.size() != 0 || ped_q.size() != 0) begin
      n_bad++;
      $display("FAIL after_done m%0d: done=%b busy=%b wr=%b fc=%h left=%0d/%0d, want 0 0 0 %h 0/0",
               mode, s_done, s_busy, s_wr, s_fc, base_q.size(),
               ped_q.size(), m_fc);
    end
  endtask

  task automatic test_skew_error();
    base_q.delete();
    ped_q.delete();
    for (int i = 0; i < 4; i++) base_q.push_back(8'(8'h40 + i));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++;
      if ({s_wr, s_brd, s_prd} !== 3'b000 || s_err !== (k >= TO + 1) ||
          s_busy !== (k < TO + 1)) begin
        n_bad++;
        $display("FAIL skew_err k%0d: rd/wr=%b err=%b busy=%b, want 000 %b %b",
                 k, {s_wr, s_brd, s_prd}, s_err, s_busy,
                 k >= TO + 1, k < TO + 1);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if (s_err !== 1'b1 || s_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL error_sticky: err=%b busy=%b, want 1 0", s_err, s_busy);
    end
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (s_err !== 1'b0 || s_busy !== 1'b0 || s_wr !== 1'b0) begin
        n_bad++;
        $display("FAIL clear k%0d: err=%b busy=%b wr=%b, want 0 0 0",
                 k, s_err, s_busy, s_wr);
      end
    end
    base_q.delete();
  endtask

  task automatic test_skew_recover();
    int          idx;
    int          pn;
    bit          ef;
    logic [15:0] ed;
    idx = 0;
    pn = 0;
    base_q.delete();
    ped_q.delete();
    for (int i = 0; i < N; i++) base_q.push_back(8'(8'h50 + i));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && idx < N; c++) begin
      if (c == 10 || c == 29) begin
        for (int j = 0; j < 4; j++) begin
          ped_q.push_back(8'(8'h60 + pn));
          pn++;
        end
      end
      ef = base_q.size() != 0 && ped_q.size() != 0;
      ed = ef ? {base_q[0], ped_q[0]} : 16'h0000;
      tick();
      n_vec++;
      if (s_wr !== ef || s_err !== 1'b0 || s_busy !== 1'b1 ||
          (ef && s_din !== ed)) begin
        n_bad++;
        $display("FAIL skew_recover c%0d: wr=%b err=%b busy=%b din=%h, want %b 0 1 %h",
                 c, s_wr, s_err, s_busy, s_din, ef, ed);
      end
      if (ef) idx++;
    end
    m_fc = m_fc + 16'h1;
    tick();
    n_vec++;
    if (idx != N || s_done !== 1'b1 || s_fc !== m_fc) begin
      n_bad++;
      $display("FAIL skew_recover_done: pairs=%0d done=%b fc=%h, want %0d 1 %h",
               idx, s_done, s_fc, N, m_fc);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    base_q.delete();
    ped_q.delete();
    for (int i = 0; i < N; i++) begin
      base_q.push_back(8'(8'h70 + i));
      ped_q.push_back(8'(8'h80 + i));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (s_wr !== 1'b1 || s_busy !== 1'b1 || s_fc !== m_fc) begin
        n_bad++;
        $display("FAIL midframe_fire k%0d: wr=%b busy=%b fc=%h, want 1 1 %h",
                 k, s_wr, s_busy, s_fc, m_fc);
      end
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({out_wr_en, base_rd_en, ped_rd_en, out_sof, out_eof,
         busy, done, error} !== 8'h00 ||
        frame_count !== 16'h0000 || out_din !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_reset: got %b fc=%h din=%h, want 0",
               {out_wr_en, base_rd_en, ped_rd_en, out_sof, out_eof,
                busy, done, error}, frame_count, out_din);
    end
    tick();
    reset = 1'b0;
    m_fc = 16'h0000;
    test_frame(0, 1'b0);
  endtask

  task automatic test_wrap();
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    #1;
    m_fc = 16'hFFFF;
    n_vec++;
    if (frame_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL preload: got %h, want ffff", frame_count);
    end
    test_frame(0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    out_full = 1'b0;
    hold_b = 0;
    hold_p = 0;
    test_reset();
    test_frame(0, 1'b0);
    test_frame(1, 1'b0);
    for (int r = 0; r < 6; r++) test_frame(2, 1'b0);
    test_skew_error();
    test_skew_recover();
    test_reset_midframe();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
